// File: rtl/transmit_beamformer_steered.sv
// Steerable burst-gated transmit beamformer: circular delay line feeding NUM_CH delayed channels.
// Optional macro TX_APODIZATION_EN halves the amplitude of the two edge channels.
module transmit_beamformer_steered #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 1024,
    parameter int STEP_W = 8,
    parameter int LEN_W  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              wave_in,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [STEP_W-1:0]             cmd_step,
    input  logic [LEN_W-1:0]              cmd_len,
    output logic [NUM_CH-1:0][WIDTH-1:0]  tx_out,
    output logic [NUM_CH-1:0]             tx_active,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err
);

    localparam int AW    = $clog2(DEPTH);
    localparam int D_W   = STEP_W + $clog2(NUM_CH);
    localparam int CNT_W = LEN_W + 1 + AW;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FIRE} state_t;

    state_t               r_state, w_state_next;
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_d [NUM_CH];
    logic [LEN_W-1:0]     r_len;
    logic [AW-1:0]        r_dmax;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_done;
    logic                 r_cfg_err;
    logic [NUM_CH-1:0]    r_act;
    logic [NUM_CH-1:0]    r_byp_sel;
    logic [WIDTH-1:0]     r_wave;

    logic [STEP_W-1:0]    w_s;
    logic [D_W-1:0]       w_d_full [NUM_CH];
    logic [D_W-1:0]       w_dmax;
    logic                 w_reject;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_running;
    logic [CNT_W-1:0]     w_c_next;
    logic [NUM_CH-1:0]    w_act_next;

    // Magnitude of the signed step; the most negative step maps to 2^(STEP_W-1).
    assign w_s      = cmd_step[STEP_W-1] ? (~cmd_step + STEP_W'(1)) : cmd_step;
    assign w_dmax   = D_W'(NUM_CH - 1) * D_W'(w_s);
    assign w_reject = (cmd_len == '0) || (32'(w_dmax) > 32'(DEPTH - 2));
    assign w_accept = cmd_valid && cmd_ready;

    assign w_last    = (r_cnt == (CNT_W'(r_len) + CNT_W'(r_dmax) - CNT_W'(1)));
    assign w_running = (r_state == S_LOAD) || ((r_state == S_FIRE) && !w_last);
    assign w_c_next  = (r_state == S_LOAD) ? '0 : (r_cnt + CNT_W'(1));

    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid && !w_reject)
                    w_state_next = S_LOAD;
            end
            S_LOAD: begin
                busy         = 1'b1;
                w_state_next = S_FIRE;
            end
            S_FIRE: begin
                busy = 1'b1;
                if (w_last)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_wr_ptr  <= '0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
            r_act     <= '0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_state_next;
            r_wr_ptr  <= r_wr_ptr + AW'(1);
            r_done    <= (r_state == S_FIRE) && w_last;
            r_cfg_err <= w_accept && w_reject;
            r_act     <= w_act_next;
            if (r_state == S_LOAD)
                r_cnt <= '0;
            else if (r_state == S_FIRE)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Burst parameters only need to be valid while busy, so they carry no reset.
    always_ff @(posedge clk) begin
        r_wave <= wave_in;
        if (w_accept && !w_reject) begin
            r_len  <= cmd_len;
            r_dmax <= AW'(w_dmax);
            for (int i = 0; i < NUM_CH; i++)
                r_d[i] <= AW'(w_d_full[i]);
        end
    end

    assign done    = r_done;
    assign cfg_err = r_cfg_err;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [WIDTH-1:0] r_q;
        logic [WIDTH-1:0] w_sel;
        logic [WIDTH-1:0] w_val;
        logic [AW-1:0]    w_raddr;

        // Positive steps delay high-index elements; negative steps mirror the ramp.
        assign w_d_full[gi] = cmd_step[STEP_W-1] ? (D_W'(NUM_CH - 1 - gi) * D_W'(w_s))
                                                 : (D_W'(gi) * D_W'(w_s));

        assign w_act_next[gi] = w_running
                             && (w_c_next >= CNT_W'(r_d[gi]))
                             && (w_c_next <  (CNT_W'(r_d[gi]) + CNT_W'(r_len)));

        // Address of the sample written d cycles ago; d==0 would collide with the write, so bypass.
        assign w_raddr = r_wr_ptr - r_d[gi];

        always_ff @(posedge clk) begin
            if (!rst)
                r_mem[r_wr_ptr] <= wave_in;
            r_q          <= r_mem[w_raddr];
            r_byp_sel[gi] <= (r_d[gi] == '0);
        end

        assign w_sel = r_byp_sel[gi] ? r_wave : r_q;

`ifdef TX_APODIZATION_EN
        if ((gi == 0) || (gi == NUM_CH - 1)) begin : g_edge
            assign w_val = {w_sel[WIDTH-1], w_sel[WIDTH-1:1]};
        end else begin : g_inner
            assign w_val = w_sel;
        end
`else
        assign w_val = w_sel;
`endif

        assign tx_out[gi]    = r_act[gi] ? w_val : '0;
        assign tx_active[gi] = r_act[gi];
    end

endmodule

// File: tb/tb_transmit_beamformer_steered.sv
// Randomized bench for transmit_beamformer_steered against a cycle-indexed burst model.
module tb_transmit_beamformer_steered;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 16;
    localparam int DEPTH  = 256;
    localparam int STEP_W = 8;
    localparam int LEN_W  = 16;
    localparam int MAXC   = 20000;
    localparam int NSCR   = 40;
    localparam int GUARD  = 300;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [WIDTH-1:0]              wave_in;
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [STEP_W-1:0]             cmd_step;
    logic [LEN_W-1:0]              cmd_len;
    logic [NUM_CH-1:0][WIDTH-1:0]  tx_out;
    logic [NUM_CH-1:0]             tx_active;
    logic                          busy;
    logic                          done;
    logic                          cfg_err;

    transmit_beamformer_steered #(
        .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEPTH(DEPTH), .STEP_W(STEP_W), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .wave_in(wave_in),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_step(cmd_step), .cmd_len(cmd_len),
        .tx_out(tx_out), .tx_active(tx_active),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Script of burst commands; first six are the directed scenarios.
    int scr_step [NSCR];
    int scr_len  [NSCR];

    logic signed [WIDTH-1:0] wave_log [MAXC+2];

    // Model of the single burst currently owned by the beamformer.
    int  b_valid, b_S, b_len, b_dmax;
    int  b_d [NUM_CH];
    int  cfg_at;
    int  cyc, since_rst, scr_idx, acc_idx, drain;
    bit  rst_done5;

    initial begin
        int s, st;
        bit rst_now, ready_e, busy_e, done_e, cfg_e, act_e;
        logic signed [WIDTH-1:0] val;

        scr_step[0] = 3;   scr_len[0] = 8;
        scr_step[1] = -2;  scr_len[1] = 4;
        scr_step[2] = 127; scr_len[2] = 8;
        scr_step[3] = 5;   scr_len[3] = 0;
        scr_step[4] = 3;   scr_len[4] = 8;
        scr_step[5] = 0;   scr_len[5] = 6;
        for (int k = 6; k < NSCR; k++) begin
            int r;
            r = int'($urandom % 10);
            if (r == 0)
                scr_step[k] = ($urandom % 2 == 0) ? 127 : -100;
            else
                scr_step[k] = int'($urandom_range(0, 80)) - 40;
            scr_len[k] = (r == 1) ? 0 : int'($urandom_range(1, 24));
        end

        b_valid = 0; b_S = 0; b_len = 0; b_dmax = 0; cfg_at = -1;
        for (int i = 0; i < NUM_CH; i++) b_d[i] = 0;
        cyc = 0; since_rst = 0; scr_idx = 0; acc_idx = -1; drain = 0; rst_done5 = 0;

        rst = 1'b1; cmd_valid = 1'b0; cmd_step = '0; cmd_len = '0; wave_in = '0;

        while (cyc < MAXC && !(scr_idx >= NSCR && drain >= 400)) begin
            @(posedge clk);
            #1;
            cyc++;

            busy_e  = b_valid != 0 && cyc >= b_S - 1 && cyc <= b_S + b_len + b_dmax - 1;
            done_e  = b_valid != 0 && cyc == b_S + b_len + b_dmax;
            cfg_e   = (cyc == cfg_at);
            ready_e = !busy_e;
            check_eq("cmd_ready", 64'(cmd_ready), 64'(ready_e));
            check_eq("busy",      64'(busy),      64'(busy_e));
            check_eq("done",      64'(done),      64'(done_e));
            check_eq("cfg_err",   64'(cfg_err),   64'(cfg_e));
            for (int i = 0; i < NUM_CH; i++) begin
                act_e = b_valid != 0 && cyc >= b_S + b_d[i] && cyc <= b_S + b_d[i] + b_len - 1;
                val   = act_e ? wave_log[cyc - b_d[i] - 1] : '0;
`ifdef TX_APODIZATION_EN
                if (i == 0 || i == NUM_CH - 1) val = val >>> 1;
`endif
                check_eq($sformatf("tx_active[%0d]", i), 64'(tx_active[i]), 64'(act_e));
                check_eq($sformatf("tx_out[%0d]", i), 64'(tx_out[i]), 64'($unsigned(val)));
            end

            // Drive the inputs for this cycle.
            rst_now = (cyc < 3);
            if (acc_idx == 4 && !rst_done5 && b_valid != 0 && cyc == b_S + 5) begin
                rst_now = 1'b1;
                rst_done5 = 1'b1;
            end
            rst = rst_now;

            if (scr_idx == 5 || acc_idx == 5)
                wave_in = 16'hFFFD;
            else
                wave_in = WIDTH'($urandom);

            if (rst_now) begin
                cmd_valid = 1'($urandom);
                cmd_step  = STEP_W'($urandom);
                cmd_len   = LEN_W'($urandom);
            end else if (since_rst > GUARD && scr_idx < NSCR) begin
                cmd_valid = ($urandom % 4) != 0;
                cmd_step  = STEP_W'(scr_step[scr_idx]);
                cmd_len   = LEN_W'(scr_len[scr_idx]);
            end else begin
                cmd_valid = 1'b0;
                cmd_step  = STEP_W'($urandom);
                cmd_len   = LEN_W'($urandom);
            end

            if (rst_now) begin
                b_valid = 0;
                cfg_at = -1;
                since_rst = 0;
            end else begin
                wave_log[cyc] = wave_in;
                since_rst++;
                if (cmd_valid && ready_e) begin
                    st = scr_step[scr_idx];
                    s  = (st < 0) ? -st : st;
                    if (scr_len[scr_idx] == 0 || (NUM_CH - 1) * s > DEPTH - 2) begin
                        cfg_at = cyc + 1;
                    end else begin
                        b_valid = 1;
                        b_S     = cyc + 2;
                        b_len   = scr_len[scr_idx];
                        b_dmax  = (NUM_CH - 1) * s;
                        for (int i = 0; i < NUM_CH; i++)
                            b_d[i] = (st >= 0) ? i * s : (NUM_CH - 1 - i) * s;
                    end
                    $display("cmd %0d accepted at cycle %0d: step=%0d len=%0d", scr_idx, cyc, st, scr_len[scr_idx]);
                    acc_idx = scr_idx;
                    scr_idx++;
                end
            end
            if (scr_idx >= NSCR) drain++;
        end

        check_eq("script_done", 64'(scr_idx), 64'(NSCR));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
